// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the multi-cycle multiply/divide unit:
//   - operation encodings (MULT/MULTU/DIV/DIVU)
//   - FSM state encodings (IDLE/RUN/FIX)
//   - iteration count and the divide-by-zero LO value
//   - abs32(): magnitude of an operand when treated as signed
// Optional feature macro used by the unit: MULDIV_CANCEL_EN
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int MULDIV_ITER = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } muldiv_op_e;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    // Magnitude of v; unsigned operands pass through untouched.
    // 0x8000_0000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// -----------------------------------------------------------------------------
// muldiv_sign_fix
// Combinational sign correction of the unsigned iteration result.
//   acc_i      in  64  multiply: unsigned product; divide: {remainder, quotient}
//   is_div_i   in   1  select divide interpretation of acc_i
//   neg_main_i in   1  negate product (multiply) or quotient (divide)
//   neg_rem_i  in   1  negate remainder (divide only)
//   hi_o       out 32  value destined for HI
//   lo_o       out 32  value destined for LO
// -----------------------------------------------------------------------------
module muldiv_sign_fix
    import muldiv_pkg::*;
(
    input  logic [63:0] acc_i,
    input  logic        is_div_i,
    input  logic        neg_main_i,
    input  logic        neg_rem_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [63:0] prod_neg;
    logic [31:0] rem_mag;
    logic [31:0] quo_mag;

    assign prod_neg = 64'd0 - acc_i;
    assign rem_mag  = acc_i[63:32];
    assign quo_mag  = acc_i[31:0];

    always_comb begin
        if (is_div_i) begin
            hi_o = neg_rem_i  ? (32'd0 - rem_mag) : rem_mag;
            lo_o = neg_main_i ? (32'd0 - quo_mag) : quo_mag;
        end else begin
            {hi_o, lo_o} = neg_main_i ? prod_neg : acc_i;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Multi-cycle MIPS32 MULT/MULTU/DIV/DIVU with architectural HI/LO registers and
// MTHI/MTLO write port. One result bit per cycle (shift-add multiply, restoring
// divide) on magnitudes, with the sign applied in a final FIX cycle.
//   clk      in   1  rising-edge clock
//   reset_n  in   1  asynchronous active-low reset
//   start    in   1  begin an operation (sampled only when idle)
//   op       in   2  0 MULT, 1 MULTU, 2 DIV, 3 DIVU
//   a        in  32  multiplicand / dividend
//   b        in  32  multiplier / divisor
//   mthi     in   1  write wdata to HI (idle only)
//   mtlo     in   1  write wdata to LO (idle only)
//   wdata    in  32  MTHI/MTLO data
//   cancel   in   1  (MULDIV_CANCEL_EN only) abort an operation in flight
//   busy     out  1  operation in flight
//   done     out  1  one-cycle pulse, HI/LO updated this cycle
//   hi       out 32  HI register
//   lo       out 32  LO register
// Optional feature macro: MULDIV_CANCEL_EN adds the cancel input.
// -----------------------------------------------------------------------------
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int ITER = MULDIV_ITER
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
`ifdef MULDIV_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    muldiv_op_e    op_q, op_d;
    // Multiplicand (multiply) or divisor (divide), as a magnitude.
    logic [31:0]   opnd_q, opnd_d;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [63:0]   acc_q, acc_d;
    logic          neg_main_q, neg_main_d;
    logic          neg_rem_q, neg_rem_d;
    logic          div_zero_q, div_zero_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          done_q, done_d;

    logic          start_signed;
    logic          start_div;
    logic [31:0]   a_abs;
    logic [31:0]   b_abs;
    logic          is_div;
    logic [32:0]   mul_sum;
    logic [32:0]   div_shift;
    logic          div_ge;
    logic [31:0]   div_diff;
    logic [31:0]   div_rem;
    logic [31:0]   fix_hi;
    logic [31:0]   fix_lo;

    assign start_signed = (op == OP_MULT) || (op == OP_DIV);
    assign start_div    = (op == OP_DIV)  || (op == OP_DIVU);
    assign a_abs        = abs32(a, start_signed);
    assign b_abs        = abs32(b, start_signed);
    assign is_div       = (op_q == OP_DIV) || (op_q == OP_DIVU);

    // Shift-add step: add multiplicand when the current multiplier LSB is set,
    // then the whole accumulator shifts right by one (carry enters at bit 63).
    assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);

    // Restoring step: the shifted remainder can momentarily need 33 bits, but
    // after a successful subtract it is always below the divisor, so the
    // 32-bit wrap-around difference is exact.
    assign div_shift = {acc_q[63:32], acc_q[31]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_diff  = div_shift[31:0] - opnd_q;
    assign div_rem   = div_ge ? div_diff : div_shift[31:0];

    muldiv_sign_fix u_sign_fix (
        .acc_i      (acc_q),
        .is_div_i   (is_div),
        .neg_main_i (neg_main_q),
        .neg_rem_i  (neg_rem_q),
        .hi_o       (fix_hi),
        .lo_o       (fix_lo)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_d       = op_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        neg_main_d = neg_main_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // A move issued alongside start is dropped.
                    op_d       = muldiv_op_e'(op);
                    opnd_d     = start_div ? b_abs : a_abs;
                    acc_d      = {32'd0, (start_div ? a_abs : b_abs)};
                    neg_main_d = start_signed && (a[31] ^ b[31]);
                    neg_rem_d  = start_signed && a[31];
                    div_zero_d = start_div && (b == 32'd0);
                    count_d    = '0;
                    state_d    = S_RUN;
                end else begin
                    if (mthi) begin
                        hi_d = wdata;
                    end
                    if (mtlo) begin
                        lo_d = wdata;
                    end
                end
            end
            S_RUN: begin
                if (is_div) begin
                    acc_d = {div_rem, acc_q[30:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
                if (count_q == LAST) begin
                    count_d = '0;
                    state_d = S_FIX;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            S_FIX: begin
                // Divide by zero leaves HI = dividend naturally (the remainder
                // path with a zero divisor reproduces |a| and the sign fix
                // restores a); only LO needs overriding.
                hi_d    = fix_hi;
                lo_d    = div_zero_q ? DIV0_LO : fix_lo;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase

`ifdef MULDIV_CANCEL_EN
        // Flush: abandon the operation without touching HI/LO.
        if (cancel && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            count_d = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            op_q       <= OP_MULT;
            opnd_q     <= 32'd0;
            acc_q      <= 64'd0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_q       <= op_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            neg_main_q <= neg_main_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
// Random and directed stimulus; expected HI/LO come from plain integer
// arithmetic on the MIPS rules and are queued at issue time. A monitor pops
// and compares whenever done pulses, also checking the 33-cycle latency.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = 32'd0;
`ifdef MULDIV_CANCEL_EN
    logic        cancel = 1'b0;
`endif
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    mul_div_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .wdata   (wdata),
`ifdef MULDIV_CANCEL_EN
        .cancel  (cancel),
`endif
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] ref_hi = 32'd0;
    logic [31:0] ref_lo = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: MIPS semantics straight from the integer rules.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        int     sx, sy, sq, sr;
        longint lx, ly;
        logic [63:0] r;
        sx = x;
        sy = y;
        lx = sx;
        ly = sy;
        case (o)
            2'd0: r = lx * ly;
            2'd1: r = {32'd0, x} * {32'd0, y};
            2'd2: begin
                if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    r  = {sr, sq};
                end
            end
            default: begin
                if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
                else r = {x % y, x / y};
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compares on every done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_done: done=1 with no operation pending, expected 0");
                end else begin
                    e = sb.pop_front();
                    check("result_hi", hi, e.hi);
                    check("result_lo", lo, e.lo);
                    check("latency_cycle", 32'(cyc), 32'(e.due));
                    check("busy_at_done", {31'd0, busy}, 32'd0);
                    $display("op=%0d a=%h b=%h -> hi=%h lo=%h", e.op, e.a, e.b, hi, lo);
                end
            end
        end
    end

    // Called and returning just after a falling edge.
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL wait_idle: busy=1 after %0d cycles, expected 0", n);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic with_move);
        exp_t e;
        logic [63:0] r;
        wait_idle();
        r     = model(o, x, y);
        e.hi  = r[63:32];
        e.lo  = r[31:0];
        e.due = cyc + 34;
        e.op  = o;
        e.a   = x;
        e.b   = y;
        sb.push_back(e);
        ref_hi = r[63:32];
        ref_lo = r[31:0];
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        mthi  = with_move;
        mtlo  = with_move;
        wdata = $urandom;
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic do_move(input logic wh, input logic wl, input logic [31:0] d);
        wait_idle();
        mthi  = wh;
        mtlo  = wl;
        wdata = d;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        if (wh) ref_hi = d;
        if (wl) ref_lo = d;
        check("move_hi", hi, ref_hi);
        check("move_lo", lo, ref_lo);
        $display("move hi_en=%0d lo_en=%0d data=%h -> hi=%h lo=%h", wh, wl, d, hi, lo);
    endtask

    initial begin
        int n;
`ifdef MULDIV_CANCEL_EN
        logic [31:0] save_hi, save_lo;
        exp_t dropped;
`endif
        // Reset state
        repeat (2) @(negedge clk);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(2'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        issue(2'd3, 32'd100, 32'd0, 1'b0);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        issue(2'd2, 32'hFFFF_FF00, 32'd0, 1'b0);
        issue(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b1);

        // Move and start while busy are both ignored
        issue(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (10) @(negedge clk);
        start = 1'b1;
        op    = 2'd3;
        a     = 32'd77;
        b     = 32'd5;
        mtlo  = 1'b1;
        wdata = 32'h0000_1234;
        @(negedge clk);
        start = 1'b0;
        mtlo  = 1'b0;
        wait_idle();
        @(negedge clk);
        check("busy_stays_idle", {31'd0, busy}, 32'd0);
        do_move(1'b0, 1'b1, 32'h0000_1234);
        do_move(1'b1, 1'b1, 32'hCAFE_F00D);

        // Randomized mix, including back-to-back issue on the done cycle
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                do_move(1'($urandom), 1'($urandom), $urandom);
            end else begin
                issue(2'($urandom), pick(), pick(), ($urandom_range(0, 9) == 0));
                if ($urandom_range(0, 3) == 0) begin
                    n = $urandom_range(1, 3);
                    repeat (n) @(negedge clk);
                end
            end
        end

`ifdef MULDIV_CANCEL_EN
        // Cancel at count 10: no done, HI/LO untouched
        do_move(1'b1, 1'b1, 32'h5555_AAAA);
        save_hi = ref_hi;
        save_lo = ref_lo;
        issue(2'd2, 32'd1000, 32'd7, 1'b0);
        repeat (10) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        dropped = sb.pop_back();
        ref_hi = save_hi;
        ref_lo = save_lo;
        check("cancel_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        check("cancel_hi", hi, save_hi);
        check("cancel_lo", lo, save_lo);
        $display("cancel op=%0d a=%h b=%h -> hi=%h lo=%h", dropped.op, dropped.a, dropped.b, hi, lo);
`endif

        // Asynchronous reset mid-RUN
        do_move(1'b1, 1'b1, 32'hA5A5_0F0F);
        issue(2'd1, 32'hDEAD_BEEF, 32'h0000_0123, 1'b0);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async_reset_busy", {31'd0, busy}, 32'd0);
        check("async_reset_hi", hi, 32'd0);
        check("async_reset_lo", lo, 32'd0);
        sb.delete();
        ref_hi = 32'd0;
        ref_lo = 32'd0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        issue(2'd0, 32'hFFFF_FFF0, 32'h0000_0010, 1'b0);

        // Drain
        wait_idle();
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle integer multiply/divide unit with architectural HI/LO registers. Executes MIPS32 MULT, MULTU, DIV and DIVU and services MTHI/MTLO. Sits in the execute stage beside the ALU. Its `hi`/`lo` outputs feed the 32-bit 2:1 writeback muxes that choose between ALU/memory data and MFHI/MFLO data.

## Interface
Parameters:
- `ITER`, 32: iterations per operation; equals the operand width. Fixed for MIPS32.

Ports:
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request a new operation; sampled only when idle
- `op`  in  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU
- `a`  in  32  rs operand: multiplicand or dividend
- `b`  in  32  rt operand: multiplier or divisor
- `mthi`  in  1  write `wdata` to HI
- `mtlo`  in  1  write `wdata` to LO
- `wdata`  in  32  MTHI/MTLO data
- `busy`  out  1  operation in flight; stall MFHI/MFLO and new mul/div
- `done`  out  1  one-cycle pulse; HI/LO updated this cycle
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- States:
  - IDLE
  - RUN: iteration counter 0..ITER-1
  - FIX: sign correction and HI/LO write
- IDLE, `start`=1:
  - latch `op`
  - latch |a| and |b| for signed ops; raw values for unsigned ops
  - latch the result-sign flags
  - go to RUN, count = 0
- RUN, multiply: shift-add on a 64-bit accumulator, one multiplier bit per cycle.
- RUN, divide: restoring division, one quotient bit per cycle.
- RUN, count = ITER-1: go to FIX.
- FIX: apply signs, write HI/LO, pulse `done`, return to IDLE.
- Result signs:
  - product is negative iff the operand signs differ (MULT)
  - quotient is negative iff the operand signs differ (DIV)
  - remainder takes the dividend's sign (DIV)
- Results:
  - multiply: HI = product[63:32], LO = product[31:0]
  - divide: HI = remainder, LO = quotient
- Divide by zero (b = 0, DIV or DIVU): HI = `a`, LO = 0xFFFF_FFFF. No exception is raised. Timing is the same as a normal divide.
- Signed overflow, 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0.
- `mthi`/`mtlo` in IDLE write on the same edge; both may be asserted together.
- Ignored inputs, with no state change:
  - `mthi`/`mtlo` while `busy`
  - `start` while `busy`
- `start` and `mthi`/`mtlo` together in IDLE: `start` wins and the move is dropped.

## Timing
- Reset values:
  - `hi` = 0, `lo` = 0
  - `busy` = 0, `done` = 0
  - state = IDLE, counter = 0
- Reset takes effect immediately, including mid-operation. Any partial result is discarded.
- `start` sampled at edge E0:
  - `busy` = 1 after E0, through E32
  - state is FIX after E32
  - at E33: HI/LO update, `done` = 1 for one cycle, `busy` = 0
- Latency: 33 cycles from `start` edge to result visible.
- Back-to-back: a new `start` is accepted in the cycle where `done` = 1. The next result is visible 33 cycles later.
- MTHI/MTLO latency: 1 cycle.
- Both `hi` and `lo` are registered outputs.

## Configuration
- `MULDIV_CANCEL_EN` defined:
  - adds input `cancel` (1 bit)
  - `cancel` = 1 in RUN or FIX forces IDLE at the next edge
  - HI/LO are unchanged and no `done` pulse is issued
  - `cancel` in IDLE has no effect
  - `cancel` has priority over `start` in the same cycle
  - purpose: exception/branch flush
- Not defined: the port is absent and operations always run to completion.

## Structure
- Shared package `muldiv_pkg`:
  - op encodings MULT/MULTU/DIV/DIVU
  - state encodings IDLE/RUN/FIX
  - `MULDIV_ITER` = 32
  - divide-by-zero LO constant 0xFFFF_FFFF
- One sub-module, `muldiv_sign_fix`: combinational two's-complement negate/select for the 64-bit product and for the quotient/remainder pair. The FSM and datapath stay in `mul_div_unit`.

## Test plan
- MULT a=0xFFFF_FFFE (-2), b=3 → after 33 cycles HI=0xFFFF_FFFF, LO=0xFFFF_FFFA, one-cycle `done`.
- MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF → HI=0xFFFF_FFFE, LO=0x0000_0001.
- DIV a=-7, b=2 → LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1).
- DIVU a=100, b=0 → HI=100, LO=0xFFFF_FFFF.
- DIV a=0x8000_0000, b=0xFFFF_FFFF → LO=0x8000_0000, HI=0.
- MTLO 0x1234 with `start` asserted mid-operation → both ignored.
  - Original result lands at E33.
  - Then MTLO 0x1234 in IDLE gives LO=0x1234 one cycle later.
  - With `MULDIV_CANCEL_EN`: `cancel` at count 10 leaves HI/LO unchanged, drops `busy` next cycle, and issues no `done`.
- `reset_n` low mid-RUN → immediately `busy`=0 and `hi`=`lo`=0.
